// File: rtl/m55_arb_pkg.sv
// Shared constants, types and helpers for the m55 lane-memory arbiter.
package m55_arb_pkg;

    localparam int COORD_W  = 3;
    localparam int LANE_MAX = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // True when both coordinates address a real lane of the 5x5 array.
    function automatic logic coord_ok(coord_t x, coord_t y);
        return (x <= coord_t'(LANE_MAX)) && (y <= coord_t'(LANE_MAX));
    endfunction

endpackage

// File: rtl/m55_arb_rr_pick.sv
// Combinational round-robin winner: first set bit of (req & ~excl)
// scanning upward from ptr, wrapping modulo NREQ.
module m55_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] excl,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   winner
);

    logic [NREQ-1:0] cand;

    assign cand = req & ~excl;

    // Scan candidates starting at the round-robin pointer.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path through this block can infer a latch.
        any    = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!any && cand[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/m55_arb.sv
// Round-robin arbiter sharing one m55 5x5 lane memory between NREQ
// requesters, with locked bursts and read-data tagging back to the issuer.
module m55_arb
    import m55_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1,
    parameter int DW     = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ-1:0]         wr,
    input  logic [COORD_W*NREQ-1:0] ax,
    input  logic [COORD_W*NREQ-1:0] ay,
    input  logic [COORD_W*NREQ-1:0] wx,
    input  logic [COORD_W*NREQ-1:0] wy,
    input  logic [DW*NREQ-1:0]      wd,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [DW-1:0]           rdata,
    output logic                    err,
    output coord_t                  mem_ax,
    output coord_t                  mem_ay,
    output coord_t                  mem_wx,
    output coord_t                  mem_wy,
    output logic                    mem_wr,
    output logic [DW-1:0]           mem_wd,
    input  logic [DW-1:0]           mem_rd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;

    logic [NREQ-1:0] excl;
    logic            pick_any;
    logic [PW-1:0]   pick_win;
    logic [PW-1:0]   nxt_ptr;
    logic            hold;
    logic            do_grant;
    logic            do_idle;

    // The releasing owner never wins its own hand-off decision.
    assign excl = (state == OWNED) ? gnt : '0;

    m55_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .excl   (excl),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .winner (pick_win)
    );

    assign nxt_ptr  = (pick_win == PW'(NREQ - 1)) ? '0 : PW'(pick_win + 1'b1);
    assign hold     = (state == OWNED) && req[owner] && lock[owner];
    assign do_grant = pick_any && ((state == IDLE) || !hold);
    assign do_idle  = (state == OWNED) && !hold && !pick_any;

    // Ownership FSM: grant, hold under lock, hand off or drop to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            gnt    <= '0;
        end else if (do_grant) begin
            state  <= OWNED;
            owner  <= pick_win;
            rr_ptr <= nxt_ptr;
            gnt    <= ONE << pick_win;
        end else if (do_idle) begin
            state  <= IDLE;
            gnt    <= '0;
        end
    end

    // Access cycle: the owner is granted and still requesting.
    logic   acc;
    coord_t cur_ax, cur_ay, cur_wx, cur_wy;
    logic   rd_ok, wr_ok;
    logic   push;

    assign acc    = (|(gnt & req)) && !reset;
    assign cur_ax = ax[int'(owner)*COORD_W +: COORD_W];
    assign cur_ay = ay[int'(owner)*COORD_W +: COORD_W];
    assign cur_wx = wx[int'(owner)*COORD_W +: COORD_W];
    assign cur_wy = wy[int'(owner)*COORD_W +: COORD_W];
    assign rd_ok  = coord_ok(cur_ax, cur_ay);
    assign wr_ok  = coord_ok(cur_wx, cur_wy);
    assign push   = acc && !wr[owner];

    // Memory pins follow the owner only during an access cycle, else idle at 0.
    always_comb begin
        mem_ax = '0;
        mem_ay = '0;
        mem_wx = '0;
        mem_wy = '0;
        mem_wd = '0;
        mem_wr = 1'b0;
        if (acc) begin
            mem_ax = cur_ax;
            mem_ay = cur_ay;
            mem_wx = cur_wx;
            mem_wy = cur_wy;
            mem_wd = wd[int'(owner)*DW +: DW];
            mem_wr = wr[owner] && wr_ok;
        end
    end

    // Sticky coordinate error; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (acc && (wr[owner] ? !wr_ok : !rd_ok)) begin
            err <= 1'b1;
        end
    end

    // Read tag pipeline aligned with the memory read latency.
    logic          out_v;
    logic          out_bad;
    logic [PW-1:0] out_id;

    if (RD_LAT == 0) begin : g_tag_comb
        assign out_v   = push;
        assign out_bad = !rd_ok;
        assign out_id  = owner;
    end else begin : g_tag_pipe
        logic [RD_LAT-1:0] tag_v;
        logic [RD_LAT-1:0] tag_bad;
        logic [PW-1:0]     tag_id [RD_LAT];

        // Shift tags one stage per cycle; ownership changes do not disturb them.
        always_ff @(posedge clk) begin
            // NOTE: these tag registers are reset (unlike a data store) because a stale valid bit would fire a phantom rvalid.
            if (reset) begin
                tag_v   <= '0;
                tag_bad <= '0;
                for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
            end else begin
                tag_v[0]   <= push;
                tag_bad[0] <= !rd_ok;
                tag_id[0]  <= owner;
                for (int i = 1; i < RD_LAT; i++) begin
                    tag_v[i]   <= tag_v[i-1];
                    tag_bad[i] <= tag_bad[i-1];
                    tag_id[i]  <= tag_id[i-1];
                end
            end
        end

        assign out_v   = tag_v[RD_LAT-1];
        assign out_bad = tag_bad[RD_LAT-1];
        assign out_id  = tag_id[RD_LAT-1];
    end

    assign rvalid = out_v ? (ONE << out_id) : '0;
    assign rdata  = (out_v && !out_bad) ? mem_rd : '0;

endmodule

// File: tb/tb_m55_arb.sv
// Directed self-checking bench for m55_arb (NREQ=4, RD_LAT=2) with a
// behavioural 5x5 lane memory of matching read latency.
module tb_m55_arb;

    localparam int NREQ   = 4;
    localparam int RD_LAT = 2;
    localparam int DW     = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req, lock, wr;
    logic [3*NREQ-1:0]    ax, ay, wx, wy;
    logic [DW*NREQ-1:0]   wd;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [DW-1:0]        rdata;
    logic                 err;
    logic [2:0]           mem_ax, mem_ay, mem_wx, mem_wy;
    logic                 mem_wr;
    logic [DW-1:0]        mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m55_arb #(
        .NREQ   (NREQ),
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .wr     (wr),
        .ax     (ax),
        .ay     (ay),
        .wx     (wx),
        .wy     (wy),
        .wd     (wd),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .mem_ax (mem_ax),
        .mem_ay (mem_ay),
        .mem_wx (mem_wx),
        .mem_wy (mem_wy),
        .mem_wr (mem_wr),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    // Behavioural m55: 25 lanes, writes on the edge, two-cycle read pipe.
    function automatic logic [DW-1:0] lane_init(int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    logic          mem_init;
    logic [DW-1:0] lanes [25];
    logic [DW-1:0] rd_now, pipe0, pipe1;
    logic [4:0]    ridx, widx;

    assign ridx   = 5'({2'b00, mem_ax} * 5 + {2'b00, mem_ay});
    assign widx   = 5'({2'b00, mem_wx} * 5 + {2'b00, mem_wy});
    assign rd_now = (mem_ax <= 3'd4 && mem_ay <= 3'd4) ? lanes[ridx] : '1;
    assign mem_rd = pipe1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 25; k++) lanes[k] <= lane_init(k);
        end else if (mem_wr && mem_wx <= 3'd4 && mem_wy <= 3'd4) begin
            lanes[widx] <= mem_wd;
        end
        pipe0 <= rd_now;
        pipe1 <= pipe0;
    end

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic on, logic lk, logic w, int x, int y,
                           logic [DW-1:0] d);
        req[i]           = on;
        lock[i]          = lk;
        wr[i]            = w;
        ax[3*i +: 3]     = 3'(x);
        ay[3*i +: 3]     = 3'(y);
        wx[3*i +: 3]     = 3'(x);
        wy[3*i +: 3]     = 3'(y);
        wd[DW*i +: DW]   = d;
    endtask

    task automatic clear_all();
        req  = '0;
        lock = '0;
        wr   = '0;
        ax   = '0;
        ay   = '0;
        wx   = '0;
        wy   = '0;
        wd   = '0;
    endtask

    // Lane contents seen by the burst: lane (2,3) was rewritten to 0xDEAD.
    function automatic logic [DW-1:0] exp_burst(int k);
        return (k == 13) ? 64'hDEAD : lane_init(k);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] exp_g, exp_rv;
        int rv0_cnt;

        clear_all();
        reset    = 1'b1;
        mem_init = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_gnt",    64'(gnt),    64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_err",    64'(err),    64'h0);
        check("rst_mem_wr", 64'(mem_wr), 64'h0);
        check("rst_mem_ax", 64'(mem_ax), 64'h0);
        reset    = 1'b0;
        mem_init = 1'b0;

        // Single write from requester 0.
        set_req(0, 1'b1, 1'b0, 1'b1, 2, 3, 64'hDEAD);
        #1;
        check("t1_gnt_latency", 64'(gnt),    64'h0);
        check("t1_no_wr_idle",  64'(mem_wr), 64'h0);
        tick();
        check("t1_gnt",    64'(gnt),    64'h1);
        check("t1_mem_wr", 64'(mem_wr), 64'h1);
        check("t1_mem_wx", 64'(mem_wx), 64'h2);
        check("t1_mem_wy", 64'(mem_wy), 64'h3);
        check("t1_mem_wd", mem_wd,      64'hDEAD);
        tick();
        clear_all();
        #1;
        check("t1_release",  64'(gnt),    64'h0);
        check("t1_wr_after", 64'(mem_wr), 64'h0);

        // Locked 25-read burst on requester 0 while requester 1 waits.
        set_req(0, 1'b1, 1'b1, 1'b0, 0, 0, '0);
        tick();
        rv0_cnt = 0;
        for (int k = 0; k < 28; k++) begin
            if (k > 0) tick();
            if (k <= 24) set_req(0, 1'b1, (k < 24), 1'b0, k / 5, k % 5, '0);
            else         set_req(0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
            if (k <= 25) set_req(1, 1'b1, 1'b0, 1'b1, 0, 4, 64'hBEEF);
            else         set_req(1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
            #1;
            exp_g  = (k <= 24) ? 4'b0001 : ((k == 25) ? 4'b0010 : 4'b0000);
            exp_rv = (k >= 2 && k <= 26) ? 4'b0001 : 4'b0000;
            check($sformatf("t2_gnt_%0d", k),    64'(gnt),    64'(exp_g));
            check($sformatf("t2_rvalid_%0d", k), 64'(rvalid), 64'(exp_rv));
            if (exp_rv != 0)
                check($sformatf("t2_rdata_%0d", k), rdata, exp_burst(k - 2));
            if (rvalid[0]) rv0_cnt++;
            if (k == 25) begin
                check("t2_h1_mem_wr", 64'(mem_wr), 64'h1);
                check("t2_h1_mem_wd", mem_wd,      64'hBEEF);
            end
        end
        check("t2_rvalid_count", 64'(rv0_cnt), 64'd25);

        // Reset, then all four request non-locked: strict rotation 0,1,2,3,0...
        reset = 1'b1;
        clear_all();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, i, i, '0);
        #1;
        check("t3_gnt_idle", 64'(gnt), 64'h0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp_g = 4'b0001 << ((j - 1) % 4);
            check($sformatf("t3_gnt_%0d", j), 64'(gnt), 64'(exp_g));
        end
        clear_all();
        tick();
        tick();
        tick();

        // Write lane (4,4), then read it back and time the rvalid pulse.
        set_req(2, 1'b1, 1'b0, 1'b1, 4, 4, 64'h0123_4567_89AB_CDEF);
        tick();
        check("t4_wr_gnt", 64'(gnt),    64'h4);
        check("t4_wr",     64'(mem_wr), 64'h1);
        tick();
        set_req(2, 1'b1, 1'b0, 1'b0, 4, 4, '0);
        tick();
        check("t4_rd_gnt", 64'(gnt), 64'h4);
        check("t4_rd_ax",  64'(mem_ax), 64'h4);
        tick();
        clear_all();
        #1;
        check("t4_rvalid_lat1", 64'(rvalid), 64'h0);
        tick();
        check("t4_rvalid_lat2", 64'(rvalid), 64'h4);
        check("t4_rdata",       rdata,       64'h0123_4567_89AB_CDEF);
        tick();
        check("t4_rvalid_once", 64'(rvalid), 64'h0);

        // Out-of-range write is suppressed and sets sticky err; bad read returns 0.
        check("t5_err_pre", 64'(err), 64'h0);
        set_req(3, 1'b1, 1'b0, 1'b1, 5, 0, 64'h5555);
        tick();
        check("t5_gnt",      64'(gnt),    64'h8);
        check("t5_wr_supp",  64'(mem_wr), 64'h0);
        tick();
        check("t5_err_set", 64'(err), 64'h1);
        set_req(3, 1'b1, 1'b0, 1'b0, 1, 7, '0);
        tick();
        check("t5_rd_gnt", 64'(gnt), 64'h8);
        tick();
        clear_all();
        tick();
        check("t5_rvalid",     64'(rvalid), 64'h8);
        check("t5_rdata_zero", rdata,       64'h0);
        check("t5_err_sticky", 64'(err),    64'h1);
        tick();

        // Reset in the middle of a locked burst with reads in flight.
        set_req(2, 1'b1, 1'b1, 1'b0, 0, 1, '0);
        tick();
        set_req(1, 1'b1, 1'b0, 1'b0, 1, 1, '0);
        set_req(3, 1'b1, 1'b0, 1'b0, 2, 2, '0);
        #1;
        check("t6_gnt_s0", 64'(gnt), 64'h4);
        tick();
        check("t6_gnt_hold", 64'(gnt), 64'h4);
        reset = 1'b1;
        #1;
        check("t6_mem_wr_rst", 64'(mem_wr), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        check("t6_gnt_after_rst",    64'(gnt),    64'h0);
        check("t6_rvalid_after_rst", 64'(rvalid), 64'h0);
        check("t6_err_after_rst",    64'(err),    64'h0);
        tick();
        check("t6_first_gnt_lowest", 64'(gnt),    64'h2);
        check("t6_rvalid_dropped",   64'(rvalid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
